// File: rtl/modulo_debounce_botoes_pkg.sv
// Shared definitions for the panel input front end:
// channel FSM encoding and default debounce/repeat timing.
package pkg_pbl;

  typedef enum logic [1:0] {
    EST_SOLTO      = 2'b00,
    EST_CONF_PRESS = 2'b01,
    EST_PRESS      = 2'b11,
    EST_CONF_SOLTO = 2'b10
  } estado_t;

  localparam int N_BOTOES_PAD    = 2;
  localparam int DEB_CICLOS_PAD  = 16;
  localparam int REPETE_PAD      = 0;
  localparam int REP_ATRASO_PAD  = 64;
  localparam int REP_PERIODO_PAD = 16;

  function automatic int maior(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/modulo_debounce_canal.sv
// One push-button channel: 2-flop synchronizer, confirmation
// FSM, hold-to-repeat timer and registered level/strobe.
module modulo_debounce_canal
  import pkg_pbl::*;
#(
  parameter int DEB_CICLOS  = DEB_CICLOS_PAD,
  parameter int REPETE      = REPETE_PAD,
  parameter int REP_ATRASO  = REP_ATRASO_PAD,
  parameter int REP_PERIODO = REP_PERIODO_PAD
) (
  input  logic clk,
  input  logic clr,
  input  logic botao_n,
  output logic pressionado,
  output logic pulso
);

  localparam int CW = $clog2(DEB_CICLOS + 1);
  localparam int RW =
    $clog2(maior(REP_ATRASO, REP_PERIODO) + 1);

  localparam logic [CW-1:0] CNT_FIM = CW'(DEB_CICLOS);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);
  localparam logic [RW-1:0] ATR_FIM = RW'(REP_ATRASO - 1);
  localparam logic [RW-1:0] PER_FIM = RW'(REP_PERIODO - 1);
  localparam logic [RW-1:0] RCNT_UM = RW'(1);

  logic          sync1;
  logic          sync2;
  logic          s;
  estado_t       estado;
  estado_t       estado_prox;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_prox;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_prox;
  logic [RW-1:0] rcnt_lim;
  logic          rep_ativo;
  logic          rep_ativo_prox;
  logic          pulso_prox;
  logic          press_prox;

  assign s = ~sync2;

  // first repeat waits the long delay, later ones the period
  assign rcnt_lim = rep_ativo ? PER_FIM : ATR_FIM;

  always_comb begin
    estado_prox    = estado;
    cnt_prox       = cnt;
    rcnt_prox      = rcnt;
    rep_ativo_prox = rep_ativo;
    pulso_prox     = 1'b0;
    unique case (estado)
      EST_SOLTO: begin
        if (s) begin
          estado_prox = EST_CONF_PRESS;
          cnt_prox    = CNT_UM;
        end
      end
      EST_CONF_PRESS: begin
        if (!s) begin
          estado_prox = EST_SOLTO;
          cnt_prox    = '0;
        end else if (cnt == CNT_FIM) begin
          estado_prox    = EST_PRESS;
          rcnt_prox      = '0;
          rep_ativo_prox = 1'b0;
          pulso_prox     = 1'b1;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end
      EST_PRESS: begin
        if (!s) begin
          estado_prox = EST_CONF_SOLTO;
          cnt_prox    = CNT_UM;
        end else if (REPETE != 0) begin
          if (rcnt == rcnt_lim) begin
            rcnt_prox      = '0;
            rep_ativo_prox = 1'b1;
            pulso_prox     = 1'b1;
          end else begin
            rcnt_prox = rcnt + RCNT_UM;
          end
        end
      end
      EST_CONF_SOLTO: begin
        if (s) begin
          estado_prox    = EST_PRESS;
          rcnt_prox      = '0;
          rep_ativo_prox = 1'b0;
        end else if (cnt == CNT_FIM) begin
          estado_prox = EST_SOLTO;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end
      default: begin
        estado_prox = EST_SOLTO;
        cnt_prox    = '0;
      end
    endcase
  end

  assign press_prox = (estado_prox == EST_PRESS) ||
                      (estado_prox == EST_CONF_SOLTO);

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      estado      <= EST_SOLTO;
      cnt         <= '0;
      rcnt        <= '0;
      rep_ativo   <= 1'b0;
      pressionado <= 1'b0;
      pulso       <= 1'b0;
    end else begin
      sync1       <= botao_n;
      sync2       <= sync1;
      estado      <= estado_prox;
      cnt         <= cnt_prox;
      rcnt        <= rcnt_prox;
      rep_ativo   <= rep_ativo_prox;
      pressionado <= press_prox;
      pulso       <= pulso_prox;
    end
  end

endmodule

// File: rtl/modulo_debounce_botoes.sv
// Operator-panel key front end: one independent debounce
// channel per raw active-low push-button.
module modulo_debounce_botoes
  import pkg_pbl::*;
#(
  parameter int N_BOTOES    = N_BOTOES_PAD,
  parameter int DEB_CICLOS  = DEB_CICLOS_PAD,
  parameter int REPETE      = REPETE_PAD,
  parameter int REP_ATRASO  = REP_ATRASO_PAD,
  parameter int REP_PERIODO = REP_PERIODO_PAD
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [N_BOTOES-1:0] botao_n,
  output logic [N_BOTOES-1:0] pressionado,
  output logic [N_BOTOES-1:0] pulso
);

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    modulo_debounce_canal #(
      .DEB_CICLOS (DEB_CICLOS),
      .REPETE     (REPETE),
      .REP_ATRASO (REP_ATRASO),
      .REP_PERIODO(REP_PERIODO)
    ) u_canal (
      .clk        (clk),
      .clr        (clr),
      .botao_n    (botao_n[i]),
      .pressionado(pressionado[i]),
      .pulso      (pulso[i])
    );
  end

endmodule
